pipelined_barrel_shifter: RTL

Parametrised, pipelined successor to the 8-bit combinational rotate-right unit. It supports rotate right/left, logical shift right/left and arithmetic shift right on a WIDTH-bit operand. It is built as a log-shifter with one register stage per shift-amount bit, and provides a shifted-out carry flag and valid/ready handshakes on both sides. It sits in the ALU datapath between operand fetch and writeback and accepts one operation per cycle.

---
 rtl/pipelined_barrel_shifter_if.sv | 56 +++++
 rtl/pipelined_barrel_shifter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_if
// Description : Handshake and data bundle for the pipelined barrel shifter.
//               The upstream operation channel (in_*) and the downstream
//               result channel (out_*) each carry a valid/ready pair.
//               master : the ALU datapath side that issues operations and
//                        consumes results.
//               slave  : the shifter itself.
// Ports       : in_valid/in_ready/in_data/in_amt/in_mode  operation channel
//               out_valid/out_ready/out_data/out_carry/out_err result channel
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_err;

    modport master (
        output in_valid,
        output in_data,
        output in_amt,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_carry,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_amt,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_carry,
        output out_err
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : WIDTH-bit log shifter supporting ROR, ROL, SHR, SHL and ASR.
//               Stage k shifts by 2^k when bit k of the amount is set, so the
//               pipeline is SHW = log2(WIDTH) stages deep and accepts one
//               operation per cycle. A carry flag reports the last bit that
//               left the operand; reserved modes pass the operand unchanged
//               and raise out_err.
// Ports       : clk            rising-edge clock
//               rst            synchronous active-high reset
//               bus (slave)    in_valid/in_ready/in_data/in_amt/in_mode
//                              out_valid/out_ready/out_data/out_carry/out_err
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] c_mode_ror = 3'd0;
    localparam logic [2:0] c_mode_rol = 3'd1;
    localparam logic [2:0] c_mode_shr = 3'd2;
    localparam logic [2:0] c_mode_shl = 3'd3;
    localparam logic [2:0] c_mode_asr = 3'd4;

    // Link k is the input of stage k; link SHW is the output of the last
    // stage. Amount and mode are only needed as stage inputs, so their links
    // stop at SHW-1.
    logic [WIDTH-1:0] w_lnk_data  [0:SHW];
    logic             w_lnk_carry [0:SHW];
    logic             w_lnk_err   [0:SHW];
    logic             w_lnk_valid [0:SHW];
    logic [SHW-1:0]   w_lnk_amt   [0:SHW-1];
    logic [2:0]       w_lnk_mode  [0:SHW-1];

    logic             w_advance;

    // The whole pipeline moves as one unit: it advances whenever the last
    // stage is empty or its result is being taken, so bubbles are kept.
    assign w_advance    = !w_lnk_valid[SHW] || bus.out_ready;
    // Reset flushes everything, so the block is never blocking during it;
    // anything offered while rst is high is dropped by the reset branch.
    assign bus.in_ready = w_advance || rst;

    assign w_lnk_data[0]  = bus.in_data;
    assign w_lnk_carry[0] = 1'b0;
    assign w_lnk_err[0]   = (bus.in_mode > c_mode_asr);
    assign w_lnk_valid[0] = bus.in_valid;
    assign w_lnk_amt[0]   = bus.in_amt;
    assign w_lnk_mode[0]  = bus.in_mode;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int c_step = 1 << k;

        logic [WIDTH-1:0] w_src;
        logic [WIDTH-1:0] w_shifted;
        logic             w_right;
        logic             w_shift;
        logic             w_carry;

        logic [WIDTH-1:0] r_data;
        logic             r_carry;
        logic             r_err;
        logic             r_valid;

        assign w_src = w_lnk_data[k];

        always_comb begin
            w_shifted = w_src;
            case (w_lnk_mode[k])
                c_mode_ror: w_shifted = (w_src >> c_step) | (w_src << (WIDTH - c_step));
                c_mode_rol: w_shifted = (w_src << c_step) | (w_src >> (WIDTH - c_step));
                c_mode_shr: w_shifted = w_src >> c_step;
                c_mode_shl: w_shifted = w_src << c_step;
                // The stage MSB still holds the original operand MSB, since
                // every earlier ASR stage replicated it.
                c_mode_asr: w_shifted = $unsigned($signed(w_src) >>> c_step);
                default:    w_shifted = w_src;
            endcase
        end

        assign w_right = (w_lnk_mode[k] == c_mode_ror) ||
                         (w_lnk_mode[k] == c_mode_shr) ||
                         (w_lnk_mode[k] == c_mode_asr);

        // Reserved modes never shift, which also keeps their carry at 0.
        assign w_shift = w_lnk_amt[k][k] && !w_lnk_err[k];

        // The last bit to leave a right shift by 2^k is bit 2^k-1; for a left
        // shift it is bit WIDTH-2^k. A non-shifting stage keeps the carry of
        // the most recent stage that did shift.
        assign w_carry = w_shift ? (w_right ? w_src[c_step-1] : w_src[WIDTH-c_step])
                                 : w_lnk_carry[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_carry <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_advance) begin
                r_valid <= w_lnk_valid[k];
                r_data  <= w_shift ? w_shifted : w_src;
                r_carry <= w_carry;
                r_err   <= w_lnk_err[k];
            end
        end

        assign w_lnk_data[k+1]  = r_data;
        assign w_lnk_carry[k+1] = r_carry;
        assign w_lnk_err[k+1]   = r_err;
        assign w_lnk_valid[k+1] = r_valid;

        // The last stage has no successor that needs amount or mode.
        if (k < SHW - 1) begin : g_fwd
            logic [SHW-1:0] r_amt;
            logic [2:0]     r_mode;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_amt  <= '0;
                    r_mode <= '0;
                end else if (w_advance) begin
                    r_amt  <= w_lnk_amt[k];
                    r_mode <= w_lnk_mode[k];
                end
            end

            assign w_lnk_amt[k+1]  = r_amt;
            assign w_lnk_mode[k+1] = r_mode;
        end
    end

    // Results come straight from the last stage register, so they are
    // inherently stable while the stage is held.
    assign bus.out_valid = w_lnk_valid[SHW];
    assign bus.out_data  = w_lnk_data[SHW];
    assign bus.out_carry = w_lnk_carry[SHW];
    assign bus.out_err   = w_lnk_err[SHW];

endmodule
`default_nettype wire
